operand_fetch_stage: RTL
========================

Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage directly upstream of the register file: drives rs1/rs2 read addresses, captures read values into a pipeline register, and hands operands to execute.
- Bypasses the same-cycle writeback, since a register-file write is not visible on a combinational read until the next cycle.
- Keeps a per-register busy scoreboard and stalls RAW/WAW hazards until the producer writes back.
- Valid/ready handshake on both sides; single-entry output register.

Parameters:
WORD_SIZE, 32, data/PC width; must match the register file.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  fetch offers an instruction
in_ready  output  1  stage accepts this cycle
in_instr  input  32  RV32I instruction word
in_pc  input  WORD_SIZE  instruction address
rf_rs1  output  5  register-file read address 1 (in_instr[19:15])
rf_rs2  output  5  register-file read address 2 (in_instr[24:20])
rf_rv1  input  WORD_SIZE  register-file read data 1
rf_rv2  input  WORD_SIZE  register-file read data 2
wb_en  input  1  writeback strobe, same signal driving the register-file enable
wb_rd  input  5  writeback destination
wb_data  input  WORD_SIZE  writeback value
flush  input  1  kill held instruction (branch redirect)
out_valid  output  1  operands valid to execute
out_ready  input  1  execute accepts
out_pc  output  WORD_SIZE  registered PC
out_instr  output  32  registered instruction
out_op1  output  WORD_SIZE  registered rs1 operand
out_op2  output  WORD_SIZE  registered rs2 operand
out_imm  output  WORD_SIZE  registered sign-extended immediate
out_rd  output  5  registered destination; 0 if the instruction writes no register

Behaviour:
- Reset (rst low, asynchronous): out_valid=0; all out_* data registers=0; scoreboard busy[31:0]=0. in_ready may go high in the first cycle after reset release.
- Opcode classes (in_instr[6:0]):
  - Uses rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Uses rs2: BRANCH, STORE, OP.
  - Writes rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - Any other opcode: uses no sources; out_rd=0; treated as a NOP that still flows through.
- Immediate formats, sign-extended to WORD_SIZE:
  - I: JALR, LOAD, OP-IMM.
  - S: STORE.
  - B: BRANCH, with bit0=0.
  - U: LUI, AUIPC, low 12 bits=0.
  - J: JAL, with bit0=0.
  - Other opcodes: 0.
- Operand select for each source s:
  - s==0: operand is 0.
  - Else if wb_en && wb_rd==s: operand is wb_data (bypass).
  - Else: operand is rf_rv.
- Hazard, combinational:
  - A used source s!=0 with busy[s]=1 and no matching writeback this cycle.
  - Or dest d!=0 with busy[d]=1 and no matching writeback this cycle (WAW).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, next cycle: out_valid=1 and all out_* loaded.
- If out_valid && out_ready && !accept: out_valid=0 next cycle.
- If out_valid && !out_ready: all out_* held stable (no change while stalled).
- Latency: exactly 1 cycle from accept to out_valid.
- Scoreboard:
  - busy[0] is always 0.
  - wb_en clears busy[wb_rd].
  - Accept of an instruction with rd!=0 sets busy[rd].
  - Set and clear on the same index in the same cycle: set wins.
- Flush (sampled on clk):
  - out_valid=0 next cycle.
  - If out_valid was 1 and out_rd!=0, busy[out_rd] is cleared; a same-cycle wb clear is harmless.
  - No accept in a flush cycle.
- Reset asserted mid-stall or mid-flush: everything returns to the reset state immediately, independent of clk.

Test Plan:
- Reset then ADDI x1,x0,5 (in_instr=0x00500093) with out_ready=1 -> out_valid one cycle after accept, out_rd=1, out_imm=5, out_op1=0; busy[1]=1.
- ADD x3,x1,x2 while busy[1]=1 and no writeback -> in_ready=0 held; assert wb_en=1, wb_rd=1, wb_data=0x1234 -> accepted that same cycle, out_op1=0x1234 (bypass), rf_rv1 ignored.
- out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 -> in_ready=0, out_* unchanged; out_ready=1 -> next instruction loaded on the following edge with no bubble.
- BEQ with imm=-8 (0xFE208CE3) -> out_imm=0xFFFFFFF8, out_rd=0, no busy bit set; JAL x5,+2048 -> out_imm=0x00000800, busy[5]=1.
- flush with held LW x7 (out_rd=7) -> out_valid=0 next cycle, busy[7]=0, in_ready=0 during the flush cycle; a later ADD x8,x7,x0 is accepted without stall.
- Set/clear collision: wb_en clearing x4 while accepting ADDI x4 -> busy[4]=1 afterwards; async rst pulse mid-stall -> out_valid=0 and busy=0 with no clock edge.

Source files
------------

// File: rtl/operand_fetch_stage_if.sv
// Bundles the fetch, register-file, writeback and execute-side signals of the
// operand fetch stage; the stage uses the slave view, its environment the master view.
interface operand_fetch_stage_if #(
    parameter int WORD_SIZE = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [WORD_SIZE-1:0] in_pc;

    logic [4:0]           rf_rs1;
    logic [4:0]           rf_rs2;
    logic [WORD_SIZE-1:0] rf_rv1;
    logic [WORD_SIZE-1:0] rf_rv2;

    logic                 wb_en;
    logic [4:0]           wb_rd;
    logic [WORD_SIZE-1:0] wb_data;

    logic                 flush;

    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_pc;
    logic [31:0]          out_instr;
    logic [WORD_SIZE-1:0] out_op1;
    logic [WORD_SIZE-1:0] out_op2;
    logic [WORD_SIZE-1:0] out_imm;
    logic [4:0]           out_rd;

    modport master (
        output in_valid, in_instr, in_pc, rf_rv1, rf_rv2,
               wb_en, wb_rd, wb_data, flush, out_ready,
        input  in_ready, rf_rs1, rf_rs2, out_valid, out_pc, out_instr,
               out_op1, out_op2, out_imm, out_rd
    );

    modport slave (
        input  in_valid, in_instr, in_pc, rf_rv1, rf_rv2,
               wb_en, wb_rd, wb_data, flush, out_ready,
        output in_ready, rf_rs1, rf_rs2, out_valid, out_pc, out_instr,
               out_op1, out_op2, out_imm, out_rd
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// RV32I decode/operand-fetch stage: reads rs1/rs2, bypasses same-cycle writeback,
// stalls on scoreboard RAW/WAW hazards and registers operands for execute.
module operand_fetch_stage #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_fetch_stage_if.slave bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    logic [6:0]           opcode;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd_field;
    logic [4:0]           rd_eff;
    logic                 uses_rs1;
    logic                 uses_rs2;
    logic                 writes_rd;
    imm_fmt_e             imm_fmt;
    logic [31:0]          imm32;
    logic [WORD_SIZE-1:0] imm_ext;
    logic [WORD_SIZE-1:0] op1;
    logic [WORD_SIZE-1:0] op2;

    logic                 blocked_rs1;
    logic                 blocked_rs2;
    logic                 blocked_rd;
    logic                 hazard;
    logic                 ready;
    logic                 accept;

    logic [31:0]          busy_q;
    logic [31:0]          busy_next;

    logic                 valid_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [31:0]          instr_q;
    logic [WORD_SIZE-1:0] op1_q;
    logic [WORD_SIZE-1:0] op2_q;
    logic [WORD_SIZE-1:0] imm_q;
    logic [4:0]           rd_q;

    assign opcode   = bus.in_instr[6:0];
    assign rd_field = bus.in_instr[11:7];
    assign rs1      = bus.in_instr[19:15];
    assign rs2      = bus.in_instr[24:20];

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        imm_fmt   = IMM_NONE;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
                imm_fmt   = IMM_U;
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                imm_fmt   = IMM_J;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm_fmt   = IMM_I;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_fmt  = IMM_B;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_fmt  = IMM_S;
            end
            OPC_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            default: begin
                uses_rs1  = 1'b0;
                uses_rs2  = 1'b0;
                writes_rd = 1'b0;
            end
        endcase
    end

    always_comb begin
        imm32 = 32'd0;
        case (imm_fmt)
            IMM_I: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
            IMM_S: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
            IMM_B: imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                            bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
            IMM_U: imm32 = {bus.in_instr[31:12], 12'd0};
            IMM_J: imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                            bus.in_instr[20], bus.in_instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign imm_ext = WORD_SIZE'($signed(imm32));
    assign rd_eff  = writes_rd ? rd_field : 5'd0;

    // A writeback in this cycle releases its register early so the bypass can supply it.
    assign blocked_rs1 = uses_rs1 && (rs1 != 5'd0) && busy_q[rs1]
                         && !(bus.wb_en && (bus.wb_rd == rs1));
    assign blocked_rs2 = uses_rs2 && (rs2 != 5'd0) && busy_q[rs2]
                         && !(bus.wb_en && (bus.wb_rd == rs2));
    assign blocked_rd  = (rd_eff != 5'd0) && busy_q[rd_eff]
                         && !(bus.wb_en && (bus.wb_rd == rd_eff));
    assign hazard      = blocked_rs1 || blocked_rs2 || blocked_rd;

    assign ready  = !bus.flush && !hazard && (!valid_q || bus.out_ready);
    assign accept = bus.in_valid && ready;

    always_comb begin
        op1 = bus.rf_rv1;
        if (rs1 == 5'd0) begin
            op1 = '0;
        end else if (bus.wb_en && (bus.wb_rd == rs1)) begin
            op1 = bus.wb_data;
        end
    end

    always_comb begin
        op2 = bus.rf_rv2;
        if (rs2 == 5'd0) begin
            op2 = '0;
        end else if (bus.wb_en && (bus.wb_rd == rs2)) begin
            op2 = bus.wb_data;
        end
    end

    // Clears first, then the accept's set, so a same-index collision leaves the bit set.
    always_comb begin
        busy_next = busy_q;
        if (bus.wb_en) begin
            busy_next[bus.wb_rd] = 1'b0;
        end
        if (bus.flush && valid_q && (rd_q != 5'd0)) begin
            busy_next[rd_q] = 1'b0;
        end
        if (accept && (rd_eff != 5'd0)) begin
            busy_next[rd_eff] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            pc_q    <= bus.in_pc;
            instr_q <= bus.in_instr;
            op1_q   <= op1;
            op2_q   <= op2;
            imm_q   <= imm_ext;
            rd_q    <= rd_eff;
        end else if (bus.flush || bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.rf_rs1    = rs1;
    assign bus.rf_rs2    = rs2;
    assign bus.out_valid = valid_q;
    assign bus.out_pc    = pc_q;
    assign bus.out_instr = instr_q;
    assign bus.out_op1   = op1_q;
    assign bus.out_op2   = op2_q;
    assign bus.out_imm   = imm_q;
    assign bus.out_rd    = rd_q;

endmodule
